// File: rtl/axis_arbiter_pkg.sv
// Shared helpers for the axis_arbiter request/grant arbiter and its
// priority encoder.
package axis_arbiter_pkg;

  // An index port needs at least one bit, even with a single requester.
  function automatic int enc_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/axis_arbiter_priority_encoder.sv
// Combinational priority encoder. It selects the highest-priority set bit of
// `bits` and returns it both one-hot and as a binary index.
module axis_arbiter_priority_encoder
  import axis_arbiter_pkg::*;
#(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 0
) (
  input  logic [WIDTH-1:0]                 bits,
  output logic                             valid,
  output logic [enc_width(WIDTH)-1:0]      encoded,
  output logic [WIDTH-1:0]                 unencoded
);

  localparam int                EW  = enc_width(WIDTH);
  localparam logic [WIDTH-1:0]  ONE = WIDTH'(1);

  assign valid = |bits;

  // A bit wins when no bit of higher priority is set. Each bit is compared
  // against a constant mask of its higher-priority neighbours, so there is
  // no long combinational chain.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_onehot
    localparam logic [WIDTH-1:0] BELOW  = (ONE << gi) - ONE;
    localparam logic [WIDTH-1:0] ABOVE  = ~((ONE << gi << 1) - ONE);
    localparam logic [WIDTH-1:0] HIGHER = (LSB_HIGH_PRIORITY != 0) ? BELOW : ABOVE;
    assign unencoded[gi] = bits[gi] & ~|(bits & HIGHER);
  end

  always_comb begin
    encoded = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (unencoded[i]) begin
        encoded = encoded | EW'(i);
      end
    end
  end

endmodule

// File: rtl/axis_arbiter.sv
// N-way request/grant arbiter with a registered one-hot grant, valid flag and
// encoded index. It can be fixed-priority or round-robin, and it can hold a grant.
module axis_arbiter
  import axis_arbiter_pkg::*;
#(
  parameter int PORTS                 = 4,
  parameter int ARB_TYPE_ROUND_ROBIN  = 0,
  parameter int ARB_BLOCK             = 0,
  parameter int ARB_BLOCK_ACK         = 1,
  parameter int ARB_LSB_HIGH_PRIORITY = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORTS-1:0]             request,
  input  logic [PORTS-1:0]             acknowledge,
  output logic [PORTS-1:0]             grant,
  output logic                         grant_valid,
  output logic [enc_width(PORTS)-1:0]  grant_encoded
);

  localparam int EW       = enc_width(PORTS);
  localparam bit LSB_HIGH = (ARB_LSB_HIGH_PRIORITY != 0);
  localparam bit RR       = (ARB_TYPE_ROUND_ROBIN != 0);
  localparam bit BLOCK    = (ARB_BLOCK != 0);
  localparam bit BLOCK_ACK = (ARB_BLOCK_ACK != 0);

  logic [PORTS-1:0] grant_reg, grant_next;
  logic             grant_valid_reg, grant_valid_next;
  logic [EW-1:0]    grant_encoded_reg, grant_encoded_next;
  logic [PORTS-1:0] mask_reg, mask_next;

  logic             request_valid;
  logic [EW-1:0]    request_index;
  logic [PORTS-1:0] request_onehot;
  logic             masked_valid;
  logic [EW-1:0]    masked_index;
  logic [PORTS-1:0] masked_onehot;
  logic             hold_state;

  axis_arbiter_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_enc_request (
    .bits      (request),
    .valid     (request_valid),
    .encoded   (request_index),
    .unencoded (request_onehot)
  );

  axis_arbiter_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (ARB_LSB_HIGH_PRIORITY)
  ) u_enc_masked (
    .bits      (request & mask_reg),
    .valid     (masked_valid),
    .encoded   (masked_index),
    .unencoded (masked_onehot)
  );

  // The mask keeps only ports of lower priority than the one just granted.
  // After the lowest-priority port it becomes zero, so arbitration restarts
  // from the top.
  function automatic logic [PORTS-1:0] rotate_mask(input logic [EW-1:0] idx);
    logic [PORTS-1:0] ones;
    ones = '1;
    if (LSB_HIGH) begin
      return ones << (int'(idx) + 1);
    end
    return ones >> (PORTS - int'(idx));
  endfunction

  assign hold_state = (BLOCK && !BLOCK_ACK && (|(grant_reg & request))) ||
                      (BLOCK && BLOCK_ACK && grant_valid_reg && !(|(grant_reg & acknowledge)));

  always_comb begin
    grant_next         = grant_reg;
    grant_valid_next   = grant_valid_reg;
    grant_encoded_next = grant_encoded_reg;
    mask_next          = mask_reg;

    if (hold_state) begin
      grant_next = grant_reg;
    end else if (request_valid) begin
      grant_valid_next = 1'b1;
      if (RR && masked_valid) begin
        grant_next         = masked_onehot;
        grant_encoded_next = masked_index;
        mask_next          = rotate_mask(masked_index);
      end else begin
        grant_next         = request_onehot;
        grant_encoded_next = request_index;
        if (RR) begin
          mask_next = rotate_mask(request_index);
        end
      end
    end else begin
      grant_next         = '0;
      grant_valid_next   = 1'b0;
      grant_encoded_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_reg         <= '0;
      grant_valid_reg   <= 1'b0;
      grant_encoded_reg <= '0;
      mask_reg          <= '0;
    end else begin
      grant_reg         <= grant_next;
      grant_valid_reg   <= grant_valid_next;
      grant_encoded_reg <= grant_encoded_next;
      mask_reg          <= mask_next;
    end
  end

  assign grant         = grant_reg;
  assign grant_valid   = grant_valid_reg;
  assign grant_encoded = grant_encoded_reg;

endmodule

// File: tb/tb_axis_arbiter.sv
// Scoreboard bench for axis_arbiter. Three configurations share one stimulus
// stream. Each one is compared against a port-index reference model.
module tb_axis_arbiter;

  // A: 32-port round-robin, blocking without ack, MSB high priority
  // B: 8-port round-robin, blocking with ack, LSB high priority
  // C: 5-port fixed priority, non-blocking, MSB high priority
  localparam int NA = 32, NB = 8, NC = 5;

  logic        clk;
  logic        rst;
  logic [31:0] req;
  logic [31:0] ack;

  logic [NA-1:0] grant_a;
  logic          valid_a;
  logic [4:0]    enc_a;
  logic [NB-1:0] grant_b;
  logic          valid_b;
  logic [2:0]    enc_b;
  logic [NC-1:0] grant_c;
  logic          valid_c;
  logic [2:0]    enc_c;

  axis_arbiter #(
    .PORTS(NA), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
    .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(0)
  ) dut_a (
    .clk(clk), .rst(rst), .request(req), .acknowledge(ack),
    .grant(grant_a), .grant_valid(valid_a), .grant_encoded(enc_a)
  );

  axis_arbiter #(
    .PORTS(NB), .ARB_TYPE_ROUND_ROBIN(1), .ARB_BLOCK(1),
    .ARB_BLOCK_ACK(1), .ARB_LSB_HIGH_PRIORITY(1)
  ) dut_b (
    .clk(clk), .rst(rst), .request(req[NB-1:0]), .acknowledge(ack[NB-1:0]),
    .grant(grant_b), .grant_valid(valid_b), .grant_encoded(enc_b)
  );

  axis_arbiter #(
    .PORTS(NC), .ARB_TYPE_ROUND_ROBIN(0), .ARB_BLOCK(0),
    .ARB_BLOCK_ACK(0), .ARB_LSB_HIGH_PRIORITY(0)
  ) dut_c (
    .clk(clk), .rst(rst), .request(req[NC-1:0]), .acknowledge(ack[NC-1:0]),
    .grant(grant_c), .grant_valid(valid_c), .grant_encoded(enc_c)
  );

  typedef struct {
    int          txn;
    logic [31:0] ga, gb, gc;
    logic        va, vb, vc;
    int          ea, eb, ec;
    int          fa, fb;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  // Reference model state: the index currently granted (-1 when there is none),
  // and the index granted most recently, which drives the round-robin order.
  int cur_a = -1, last_a = -1;
  int cur_b = -1, last_b = -1;
  int cur_c = -1, last_c = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // The next grant goes to the first requester below the last grant in
  // priority order. If there is none, it goes to the top requester.
  task automatic model_step(input int n, input int rr, input int blk, input int bak,
                            input int lsb, input logic [31:0] r, input logic [31:0] a,
                            inout int cur, inout int last);
    int top, below, lr, idx;
    top = -1;
    below = -1;
    lr = (last < 0) ? -1 : ((lsb != 0) ? n - 1 - last : last);
    for (int rk = n - 1; rk >= 0; rk--) begin
      idx = (lsb != 0) ? n - 1 - rk : rk;
      if (r[idx]) begin
        if (top < 0) top = idx;
        if (below < 0 && rk < lr) below = idx;
      end
    end
    if (blk != 0 && bak == 0 && cur >= 0 && r[cur]) return;
    if (blk != 0 && bak != 0 && cur >= 0 && !a[cur]) return;
    if (top < 0) begin
      cur = -1;
      return;
    end
    cur = (rr != 0 && below >= 0) ? below : top;
    if (rr != 0) last = cur;
  endtask

  function automatic logic [31:0] onehot(input int c);
    return (c < 0) ? 32'd0 : (32'd1 << c);
  endfunction

  task automatic push_exp(input int fa, input int fb);
    exp_t e;
    e.txn = txn;
    e.ga = onehot(cur_a); e.va = (cur_a >= 0); e.ea = (cur_a < 0) ? 0 : cur_a;
    e.gb = onehot(cur_b); e.vb = (cur_b >= 0); e.eb = (cur_b < 0) ? 0 : cur_b;
    e.gc = onehot(cur_c); e.vc = (cur_c >= 0); e.ec = (cur_c < 0) ? 0 : cur_c;
    e.fa = fa;
    e.fb = fb;
    exp_q.push_back(e);
    txn++;
  endtask

  task automatic reset_models();
    cur_a = -1; last_a = -1;
    cur_b = -1; last_b = -1;
    cur_c = -1; last_c = -1;
  endtask

  // fx: -2 means no directed value, -1 means no grant, otherwise the exact granted index.
  task automatic cmp(input string nm, input int t, input logic [31:0] ag, input logic av,
                     input int ae, input logic [31:0] eg, input logic ev, input int ee,
                     input int fx);
    bit ok;
    checks++;
    ok = (ag === eg) && (av === ev) && (ae == ee);
    if (fx == -1) ok = ok && (ag === 32'd0) && (av === 1'b0) && (ae == 0);
    else if (fx >= 0) ok = ok && (ag === (32'd1 << fx)) && (av === 1'b1) && (ae == fx);
    if (!ok) begin
      failures++;
      $display("FAIL %s txn %0d: got grant=%h valid=%b enc=%0d, want grant=%h valid=%b enc=%0d directed=%0d",
               nm, t, ag, av, ae, eg, ev, ee, fx);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and queue the expected
  // response for the following rising edge.
  task automatic step(input logic [31:0] r, input logic [31:0] a, input logic rv,
                      input int fa, input int fb);
    @(negedge clk);
    req = r;
    ack = a;
    rst = rv;
    if (!rv) begin
      reset_models();
    end else begin
      model_step(NA, 1, 1, 0, 0, r, a, cur_a, last_a);
      model_step(NB, 1, 1, 1, 1, r, a, cur_b, last_b);
      model_step(NC, 0, 0, 0, 0, r, a, cur_c, last_c);
    end
    push_exp(fa, fb);
  endtask

  // Assert reset in the middle of a cycle. The outputs must clear without a clock edge.
  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("async_rst_a", txn, grant_a, valid_a, int'(enc_a), 32'd0, 1'b0, 0, -2);
    cmp("async_rst_b", txn, {24'd0, grant_b}, valid_b, int'(enc_b), 32'd0, 1'b0, 0, -2);
    cmp("async_rst_c", txn, {27'd0, grant_c}, valid_c, int'(enc_c), 32'd0, 1'b0, 0, -2);
    reset_models();
    push_exp(-1, -1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("dut_a", e.txn, grant_a, valid_a, int'(enc_a), e.ga, e.va, e.ea, e.fa);
        cmp("dut_b", e.txn, {24'd0, grant_b}, valid_b, int'(enc_b), e.gb, e.vb, e.eb, e.fb);
        cmp("dut_c", e.txn, {27'd0, grant_c}, valid_c, int'(enc_c), e.gc, e.vc, e.ec, -2);
        $display("txn %0d req=%h ack=%h a=%0d/%b b=%0d/%b c=%0d/%b",
                 e.txn, req, ack, enc_a, valid_a, enc_b, valid_b, enc_c, valid_c);
      end
    end
  end

  initial begin : driver
    logic [31:0] all_ones;
    logic [31:0] r;
    logic [31:0] prev;
    logic        rv;
    all_ones = '1;
    rst = 1'b1;
    req = '0;
    ack = '0;
    #1 rst = 1'b0;
    #1;
    cmp("init_rst_a", txn, grant_a, valid_a, int'(enc_a), 32'd0, 1'b0, 0, -2);
    cmp("init_rst_b", txn, {24'd0, grant_b}, valid_b, int'(enc_b), 32'd0, 1'b0, 0, -2);

    // Reset is held, then released with no requests
    step(32'd0, 32'd0, 1'b0, -1, -1);
    step(32'd0, 32'd0, 1'b0, -1, -1);
    step(32'd0, 32'd0, 1'b1, -1, -1);
    step(32'd0, 32'd0, 1'b1, -1, -1);

    // A single request, then blocking while a higher-priority request arrives
    step(32'h0000_0020, 32'd0, 1'b1, 5, 5);
    step(32'h8000_0020, 32'd0, 1'b1, 5, -2);
    step(32'h8000_0020, 32'd0, 1'b1, 5, -2);
    step(32'h8000_0000, 32'd0, 1'b1, 31, -2);
    step(32'd0, 32'd0, 1'b1, -1, -2);
    step(32'h0000_0080, 32'd0, 1'b1, 7, -2);

    // Round-robin across 10, 5 and 0, then wrap back to 10
    reset_pulse();
    step(32'h0000_0421, 32'd0, 1'b1, 10, -2);
    step(32'h0000_0021, 32'd0, 1'b1, 5, -2);
    step(32'h0000_0421, 32'd0, 1'b1, 5, -2);
    step(32'h0000_0401, 32'd0, 1'b1, 0, -2);
    step(32'h0000_0421, 32'd0, 1'b1, 0, -2);
    step(32'h0000_0420, 32'd0, 1'b1, 10, -2);

    // All ports request; the granted bit is pulsed low each time
    reset_pulse();
    step(all_ones, 32'd0, 1'b1, 31, -2);
    for (int g = 31; g >= 0; g--) begin
      step(all_ones & ~(32'd1 << g), 32'd0, 1'b1, (g == 0) ? 31 : g - 1, -2);
      step(all_ones, 32'd0, 1'b1, (g == 0) ? 31 : g - 1, -2);
    end

    // Acknowledge-held grant: ack of another port is ignored
    reset_pulse();
    step(32'h0000_0008, 32'd0, 1'b1, 3, 3);
    step(32'd0, 32'h0000_0010, 1'b1, -1, 3);
    step(32'd0, 32'h0000_0010, 1'b1, -1, 3);
    step(32'd0, 32'h0000_0008, 1'b1, -1, -1);

    // Randomized traffic
    prev = '0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(3, 0))
        0: r = $urandom() & $urandom();
        1: r = prev;
        2: r = prev ^ (32'd1 << $urandom_range(31, 0));
        default: r = ($urandom_range(3, 0) == 0) ? 32'd0 : ($urandom() & $urandom() & $urandom());
      endcase
      rv = ($urandom_range(49, 0) != 0);
      step(r, ($urandom_range(1, 0) != 0) ? (32'd1 << $urandom_range(7, 0)) : 32'd0, rv, -2, -2);
      prev = r;
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
